sumador_serial: RTL

//  Bit-serial parameterised adder: computes y = a + b LSB-first, one bit per clock, with a full adder and a carry flop.

---
 rtl/sumador_serial.sv | 112 +++++++++++
 1 files changed

// File: rtl/sumador_serial.sv
// sumador_serial: bit-serial adder, LSB first, one full-adder bit per clock.
// Ports: clk, reset (sync, high), start, a/b in; busy, done, y, cout, overflow out.
module sumador_serial #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] y,
    output logic         cout,
    output logic         overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t       state_q;
    logic [N-1:0] ra_q;
    logic [N-1:0] rb_q;
    logic [N-1:0] res_q;
    logic [N-1:0] y_q;
    logic [CW-1:0] cnt_q;
    logic         c_q;
    logic         cout_q;
    logic         ovf_q;
    logic         busy_q;
    logic         done_q;

    logic         sum_d;
    logic         carry_d;
    logic [N-1:0] res_d;

    // Full adder on the current LSBs; the sum bit enters at the MSB so
    // that after N shifts the result sits in its natural bit order.
    always_comb begin
        sum_d   = ra_q[0] ^ rb_q[0] ^ c_q;
        carry_d = (ra_q[0] & rb_q[0]) | (c_q & (ra_q[0] ^ rb_q[0]));
        res_d   = {sum_d, res_q[N-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        ra_q    <= a;
                        rb_q    <= b;
                        res_q   <= '0;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    ra_q  <= ra_q >> 1;
                    rb_q  <= rb_q >> 1;
                    res_q <= res_d;
                    c_q   <= carry_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // c_q is the carry into the MSB here,
                        // carry_d the carry out of it.
                        y_q     <= res_d;
                        cout_q  <= carry_d;
                        ovf_q   <= c_q ^ carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign y        = y_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
